// File: rtl/haraka_s_pad_if.sv
// haraka_s_pad_if: byte-in / block-out stream bundle for haraka_s_pad
//   master: message source and block sink (drives in_*, blk_ready)
//   slave : the padder (drives in_ready, blk_*)
interface haraka_s_pad_if #(parameter int RATE_BYTES = 32);
  logic                    in_valid;
  logic [7:0]              in_byte;
  logic                    in_last;
  logic                    in_empty;
  logic                    in_ready;
  logic                    blk_valid;
  logic [8*RATE_BYTES-1:0] blk_data;
  logic                    blk_last;
  logic                    blk_ready;
  modport master (
    output in_valid, in_byte, in_last, in_empty, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );
  modport slave (
    input  in_valid, in_byte, in_last, in_empty, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/haraka_s_pad.sv
// haraka_s_pad: byte-serial Haraka-S absorb front end, packs bytes into padded 256-bit rate blocks
//   clk   : clock, all state changes on posedge
//   reset : asynchronous active-low reset
//   bus   : haraka_s_pad_if.slave, byte stream in (in_*), block stream out (blk_*)
//   msg_bytes : data bytes accepted in the current message, only with HARAKA_PAD_LEN_EN defined
module haraka_s_pad #(parameter int RATE_BYTES = 32) (
  input logic clk,
  input logic reset,
  haraka_s_pad_if.slave bus
`ifdef HARAKA_PAD_LEN_EN
  ,
  output logic [63:0] msg_bytes
`endif
);
  localparam int W = 8 * RATE_BYTES;
  localparam logic [W-1:0] PAD_BLK = {8'h1F, {(W-16){1'b0}}, 8'h80};
  typedef enum logic [1:0] {FILL, OUT, PADBLK} state_e;
  state_e state, state_n;
  logic [W-1:0] data_q, data_n;
  logic [4:0] ptr, pad_pos;
  logic last_q, last_pending, accept, data_beat, pad_en, to_out, ptr_end;
  assign ptr_end = ptr == 5'd31;
  assign accept = state == FILL && bus.in_valid;
  assign data_beat = accept && !(bus.in_last && bus.in_empty);
  // a data byte landing in slot 31 of a last beat leaves no room, so the pad spills into a PADBLK block
  assign pad_en = accept && bus.in_last && (bus.in_empty || !ptr_end);
  assign pad_pos = bus.in_empty ? ptr : ptr + 5'd1;
  assign to_out = accept && (bus.in_last || ptr_end);
  // unwritten bytes are already zero, so padding only needs the 0x1F marker and the 0x80 in byte 31
  always_comb begin
    data_n = data_q;
    if (data_beat) data_n[{~ptr, 3'b000} +: 8] = bus.in_byte;
    if (pad_en) data_n[{~pad_pos, 3'b000} +: 8] = 8'h1F;
    if (pad_en) data_n[7:0] = data_n[7:0] | 8'h80;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FILL;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == FILL) state_n = to_out ? OUT : FILL;
    else if (bus.blk_ready) state_n = (state == OUT && last_pending) ? PADBLK : FILL;
  end
  always_comb begin
    bus.in_ready = state == FILL;
    bus.blk_valid = state != FILL;
    bus.blk_last = state == PADBLK || (state == OUT && last_q);
    bus.blk_data = state == OUT ? data_q : state == PADBLK ? PAD_BLK : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data_q <= '0;
      ptr <= '0;
      last_q <= 1'b0;
      last_pending <= 1'b0;
    end else begin
      if (state == OUT && bus.blk_ready) data_q <= '0;
      else if (accept) data_q <= data_n;
      if (accept) ptr <= bus.in_last ? 5'd0 : ptr + 5'd1;
      if (to_out) last_q <= pad_en;
      if (accept && bus.in_last && !bus.in_empty && ptr_end) last_pending <= 1'b1;
      else if (state == PADBLK && bus.blk_ready) last_pending <= 1'b0;
    end
`ifdef HARAKA_PAD_LEN_EN
  logic final_hs;
  assign final_hs = bus.blk_ready && bus.blk_last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) msg_bytes <= '0;
    else if (final_hs) msg_bytes <= '0;
    else if (data_beat && !(&msg_bytes)) msg_bytes <= msg_bytes + 64'd1;
`endif
endmodule

// File: tb/tb_haraka_s_pad.sv
// tb_haraka_s_pad: directed scoreboard bench for haraka_s_pad
module tb_haraka_s_pad;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  haraka_s_pad_if #(.RATE_BYTES(32)) bus ();
`ifdef HARAKA_PAD_LEN_EN
  logic [63:0] msg_bytes;
  haraka_s_pad #(.RATE_BYTES(32)) dut (.clk(clk), .reset(reset), .bus(bus), .msg_bytes(msg_bytes));
`else
  haraka_s_pad #(.RATE_BYTES(32)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  typedef struct {
    logic [255:0] d;
    logic         l;
    longint       n;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(string tag, logic [255:0] o, logic [255:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  function automatic logic [255:0] exp_blk(int n, int base, int k);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      int idx;
      idx = k * 32 + j;
      r[255-8*j -: 8] = idx < n ? 8'(base + idx) : idx == n ? 8'h1F : 8'h00;
    end
    if (k == n / 32) r[7:0] = r[7:0] | 8'h80;
    return r;
  endfunction
  always @(negedge clk)
    if (reset && bus.blk_valid && bus.blk_ready) begin
      if (sb.size() == 0) chk("unexpected block", 256'(bus.blk_valid), 256'(0));
      else begin
        mon_e = sb.pop_front();
        chk("blk_data", bus.blk_data, mon_e.d);
        chk("blk_last", 256'(bus.blk_last), 256'(mon_e.l));
`ifdef HARAKA_PAD_LEN_EN
        if (mon_e.l) chk("msg_bytes", 256'(msg_bytes), 256'(mon_e.n));
`endif
      end
    end
  task automatic beat(logic [7:0] b, logic last, logic empty);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_byte = b;
    bus.in_last = last;
    bus.in_empty = empty;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 100);
    chk("in_ready wait", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1;
  endtask
  task automatic send(int n, int base);
    for (int k = 0; k <= n / 32; k++) sb.push_back('{exp_blk(n, base, k), k == n / 32, longint'(n)});
    if (n == 0) beat(8'h00, 1'b1, 1'b1);
    else for (int i = 0; i < n; i++) beat(8'(base + i), i == n - 1, 1'b0);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_empty = 1'b0;
  endtask
  task automatic send_partial(int n);
    for (int i = 0; i < n; i++) beat(8'(8'hA0 + i), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 256'(sb.size()), 256'(0));
    @(posedge clk);
    #1;
  endtask
  task automatic stall(int nblk);
    logic [255:0] d0;
    for (int b = 0; b < nblk; b++) begin
      int t;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.blk_valid && t < 300);
      chk("stall blk_valid", 256'(bus.blk_valid), 256'(1));
      d0 = bus.blk_data;
      repeat (5) begin
        @(negedge clk);
        chk("stall in_ready", 256'(bus.in_ready), 256'(0));
        chk("stall blk_data", bus.blk_data, d0);
      end
      @(posedge clk);
      #1 bus.blk_ready = 1'b1;
      @(posedge clk);
      #1 bus.blk_ready = 1'b0;
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    bus.in_last = 1'b0;
    bus.in_empty = 1'b0;
    bus.blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst blk_valid", 256'(bus.blk_valid), 256'(0));
    chk("rst blk_data", bus.blk_data, 256'(0));
    chk("rst blk_last", 256'(bus.blk_last), 256'(0));
`ifdef HARAKA_PAD_LEN_EN
    chk("rst msg_bytes", 256'(msg_bytes), 256'(0));
`endif
    reset = 1'b1;
    bus.blk_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3, 'h61);
    drain();
    send(0, 0);
    drain();
    send(31, 0);
    drain();
    send(32, 0);
    drain();
    bus.blk_ready = 1'b0;
    fork
      send(40, 0);
      stall(2);
    join
    bus.blk_ready = 1'b1;
    drain();
    send_partial(10);
    reset = 1'b0;
    #1;
    chk("abort in_ready", 256'(bus.in_ready), 256'(1));
    chk("abort blk_valid", 256'(bus.blk_valid), 256'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    send(3, 'h61);
    drain();
    bus.blk_ready = 1'b0;
    send_partial(32);
    chk("out before reset", 256'(bus.blk_valid), 256'(1));
    reset = 1'b0;
    #1;
    chk("async blk_valid", 256'(bus.blk_valid), 256'(0));
    chk("async blk_data", bus.blk_data, 256'(0));
    chk("async blk_last", 256'(bus.blk_last), 256'(0));
    chk("async in_ready", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1 reset = 1'b1;
    bus.blk_ready = 1'b1;
    send(3, 'h61);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/haraka_s_pad.md
# haraka_s_pad

Byte-serial absorb front end for the Haraka-S sponge. It accepts message bytes over a valid/ready stream and packs them into 256-bit rate blocks of 32 bytes. On the final block it applies Haraka-S multi-rate padding: a 0x1F domain byte, zero fill, and 0x80 OR-ed into the last byte. It sits directly upstream of the permutation/absorb stage, which XORs each emitted block into the rate half of the state.

## Interface
Parameters:
- RATE_BYTES, 32, bytes per rate block. Only the value 32 is supported; blk_data is 8*RATE_BYTES bits wide.

Ports:
- clk  input  1  single clock; all state changes on the posedge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- in_valid  input  1  the input beat is valid.
- in_byte  input  8  message byte.
- in_last  input  1  this beat ends the message.
- in_empty  input  1  with in_last, the beat carries no data byte (empty tail or empty message); ignored without in_last.
- in_ready  output  1  block can accept a beat this cycle.
- blk_valid  output  1  blk_data holds a complete block.
- blk_data  output  256  block; message byte i of the block is at [255-8i -: 8].
- blk_last  output  1  block is the final, padded block of the message.
- blk_ready  input  1  downstream consumes the block.

## Operation
- States: FILL, OUT, PADBLK.
- Counters and flags:
  - ptr is a 5-bit byte position, 0..31.
  - A last_pending flag is held.
- FILL:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready.
  - An accepted data beat writes buf[ptr] and increments ptr.
  - Non-last beat with ptr==31 goes to OUT with blk_last=0, and ptr wraps to 0.
  - Last beat with a data byte at p<31: writes the byte, applies the pad at p+1, and goes to OUT with blk_last=1.
  - Last beat with a data byte at p==31: goes to OUT with blk_last=0 and sets last_pending.
  - Last beat with in_empty: applies the pad at the current ptr and goes to OUT with blk_last=1.
- Pad rule, at position q:
  - byte q = 0x1F.
  - Bytes q+1..30 = 0x00.
  - byte 31 |= 0x80.
  - If q==31, byte 31 = 0x9F.
- OUT:
  - in_ready=0, blk_valid=1.
  - blk_data and blk_last are held stable until blk_ready.
  - On the handshake, the buffer clears to zero.
  - Next state is PADBLK if last_pending, else FILL.
- PADBLK:
  - Presents the pad-only block (byte0=0x1F, bytes1..30=0, byte31=0x80) with blk_valid=1 and blk_last=1.
  - On the handshake, clears last_pending and returns to FILL.
- After a final block is consumed, ptr=0 and the next accepted beat starts a new message.
- Byte positions not yet written in FILL are always 0, because the buffer clears on every block handshake.

## Timing
- Reset values:
  - state=FILL, ptr=0, buffer=0, last_pending=0.
  - blk_valid=0, blk_data=0, blk_last=0.
  - in_ready=1 (it is decoded from state).
- Latency: the beat completing a block, accepted at edge N, gives blk_valid=1 in cycle N+1, with padding already applied.
- Throughput: 32 bytes per 33 cycles when blk_ready is tied high, because in_ready is low for exactly one cycle per block.
- blk_valid is not dependent on blk_ready in the same cycle. blk_ready while blk_valid=0 is ignored.
- in_valid while in_ready=0 is not consumed. The source holds the beat stable until it is accepted.
- Reset asserted mid-message or mid-OUT: the partial block and the pending pad are discarded. Outputs take their reset values asynchronously.

## Configuration
- HARAKA_PAD_LEN_EN is the length-counter feature switch.
- Defined:
  - Adds the output msg_bytes [63:0].
  - The count is the number of data bytes accepted in the current message.
  - It increments on each accepted data beat (not on in_empty beats) and saturates at 2^64-1.
  - It holds its value while the final block is presented, for downstream digest bookkeeping.
  - It returns to 0 on the final-block handshake and on reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Message 61 62 63, with in_last on 63 -> one block: bytes 0..2 = 61 62 63, byte3 = 1F, bytes 4..30 = 00, byte31 = 80, blk_last=1. With the macro defined, msg_bytes=3.
- Empty message (single beat, in_last=1, in_empty=1) -> block with byte0=1F, bytes 1..30 = 00, byte31=80, blk_last=1.
- 31 bytes 00..1E -> one block, bytes 0..30 = 00..1E, byte31 = 9F, blk_last=1.
- 32 bytes 00..1F -> block 1 = 00..1F with blk_last=0; then a pad-only block 1F,00..00,80 with blk_last=1.
- 40 bytes with blk_ready held low for 5 cycles after each blk_valid rise:
  - in_ready stays 0 and blk_data stays stable while stalled.
  - Exactly two blocks are emitted; block 2 = bytes 32..39, then 1F, zeros, 80.
- Reset pulsed low after 10 bytes, then a 3-byte message is sent -> output matches the first scenario, with no residue of the aborted bytes.
